ghost_dir_ctrl: RTL

Direction-decision stage that sits directly upstream of ghost_move and drives its direction[1:0] input.
- Runs the ghost behaviour-mode state machine: IDLE, SCATTER, CHASE, FRIGHT.
- Once per frame, picks a direction toward a target point. The target is pacman in CHASE and a fixed corner in SCATTER; in FRIGHT the direction is pseudo-random.
- Excludes the direction that just caused a wall collision, and forces a reversal on every mode change.

---
 rtl/ghost_dir_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ghost_dir_ctrl.sv
// Ghost direction decision: behaviour-mode FSM plus a per-frame direction pick toward a target,
// with collision-direction exclusion and forced reversal on every mode change.
module ghost_dir_ctrl #(
  parameter int unsigned SCATTER_FRAMES = 210,
  parameter int unsigned CHASE_FRAMES   = 600,
  parameter int unsigned FRIGHT_FRAMES  = 180,
  parameter int          SCATTER_X      = 600,
  parameter int          SCATTER_Y      = 16,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               collision,
  input  logic               powerUp,
  input  logic signed [10:0] ghostX,
  input  logic signed [10:0] ghostY,
  input  logic signed [10:0] pacmanX,
  input  logic signed [10:0] pacmanY,
  input  logic [1:0]         dir_ghost,
  output logic [1:0]         direction,
  output logic [1:0]         mode,
  output logic               frightened
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCATTER = 2'd1, CHASE = 2'd2, FRIGHT = 2'd3} mode_t;

  localparam logic [9:0]         SC_N = 10'(SCATTER_FRAMES);
  localparam logic [9:0]         CH_N = 10'(CHASE_FRAMES);
  localparam logic [9:0]         FR_N = 10'(FRIGHT_FRAMES);
  localparam logic signed [10:0] SC_X = 11'(SCATTER_X);
  localparam logic signed [10:0] SC_Y = 11'(SCATTER_Y);

  mode_t              state;
  mode_t              saved_mode;
  logic [9:0]         frame_cnt;
  logic [9:0]         cnt_inc;
  logic               rev_pending;
  logic               blocked_valid;
  logic [1:0]         blocked_dir;
  logic [7:0]         lfsr;
  logic               decide;
  logic signed [10:0] tx;
  logic signed [10:0] ty;
  logic [1:0]         tgt_dir;
  logic [1:0]         frt_dir;
  logic [1:0]         norm_dir;
  logic [1:0]         rev_dir;
  logic [1:0]         dec_dir;

  function automatic logic [11:0] mag12(input logic signed [11:0] v);
    return v[11] ? 12'(-v) : 12'(v);
  endfunction

  // Larger axis distance wins; the other axis is the fallback when the primary is blocked.
  function automatic logic [1:0] target_dir(input logic signed [10:0] tgt_x,
                                            input logic signed [10:0] tgt_y,
                                            input logic signed [10:0] pos_x,
                                            input logic signed [10:0] pos_y,
                                            input logic               bv,
                                            input logic [1:0]         bd);
    logic signed [11:0] dx;
    logic signed [11:0] dy;
    logic [1:0]         hdir;
    logic [1:0]         vdir;
    logic [1:0]         prim;
    logic [1:0]         sec;
    dx   = {tgt_x[10], tgt_x} - {pos_x[10], pos_x};
    dy   = {tgt_y[10], tgt_y} - {pos_y[10], pos_y};
    hdir = dx[11] ? 2'd3 : 2'd2;
    vdir = dy[11] ? 2'd0 : 2'd1;
    if (mag12(dx) >= mag12(dy)) begin
      prim = hdir;
      sec  = vdir;
    end else begin
      prim = vdir;
      sec  = hdir;
    end
    return (bv && prim == bd) ? sec : prim;
  endfunction

  assign mode    = state;
  assign cnt_inc = frame_cnt + 10'd1;
  assign decide  = startOfFrame && (state != IDLE);

  always_comb begin
    tx       = (state == CHASE) ? pacmanX : SC_X;
    ty       = (state == CHASE) ? pacmanY : SC_Y;
    tgt_dir  = target_dir(tx, ty, ghostX, ghostY, blocked_valid, blocked_dir);
    frt_dir  = lfsr[1:0];
    if (blocked_valid && frt_dir == blocked_dir)
      frt_dir = frt_dir ^ 2'b01;
    norm_dir = (state == FRIGHT) ? frt_dir : tgt_dir;
    rev_dir  = dir_ghost ^ 2'b01;
    dec_dir  = (rev_pending && !(blocked_valid && rev_dir == blocked_dir)) ? rev_dir : norm_dir;
  end

  // Mode FSM; a transition in the decision clk re-arms rev_pending after the decision consumes it.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      saved_mode  <= SCATTER;
      frame_cnt   <= 10'd0;
      rev_pending <= 1'b0;
      frightened  <= 1'b0;
    end else begin
      if (decide)
        rev_pending <= 1'b0;
      case (state)
        IDLE: begin
          if (startOfFrame) begin
            state     <= SCATTER;
            frame_cnt <= 10'd0;
          end
        end
        SCATTER, CHASE: begin
          if (powerUp) begin
            saved_mode  <= state;
            state       <= FRIGHT;
            frightened  <= 1'b1;
            frame_cnt   <= 10'd0;
            rev_pending <= 1'b1;
          end else if (startOfFrame) begin
            if (cnt_inc == ((state == SCATTER) ? SC_N : CH_N)) begin
              state       <= (state == SCATTER) ? CHASE : SCATTER;
              frame_cnt   <= 10'd0;
              rev_pending <= 1'b1;
            end else begin
              frame_cnt <= cnt_inc;
            end
          end
        end
        FRIGHT: begin
          if (powerUp) begin
            frame_cnt <= 10'd0;
          end else if (startOfFrame) begin
            if (cnt_inc == FR_N) begin
              state       <= saved_mode;
              frightened  <= 1'b0;
              frame_cnt   <= 10'd0;
              rev_pending <= 1'b1;
            end else begin
              frame_cnt <= cnt_inc;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Direction register, blocked flag and free-running LFSR (taps 8,6,5,4).
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      direction     <= 2'd3;
      blocked_valid <= 1'b0;
      lfsr          <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (decide) begin
        direction     <= dec_dir;
        blocked_valid <= 1'b0;
      end else if (collision && !blocked_valid) begin
        blocked_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!decide && collision && !blocked_valid)
      blocked_dir <= dir_ghost;
  end

endmodule
